// File: rtl/rand_pkg.sv
// Shared types and helpers for the range-limited random generator.
package rand_pkg;

  // Request FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } state_t;

  // Galois (right-shift) feedback mask giving a maximal-length sequence for
  // the given register width. Bit (t-1) is set for each polynomial tap t.
  function automatic logic [31:0] tap_mask(input int width);
    case (width)
      4:       tap_mask = 32'h0000_000C;
      5:       tap_mask = 32'h0000_0014;
      6:       tap_mask = 32'h0000_0030;
      7:       tap_mask = 32'h0000_0060;
      8:       tap_mask = 32'h0000_00B8;
      9:       tap_mask = 32'h0000_0110;
      10:      tap_mask = 32'h0000_0240;
      11:      tap_mask = 32'h0000_0500;
      12:      tap_mask = 32'h0000_0829;
      13:      tap_mask = 32'h0000_100D;
      14:      tap_mask = 32'h0000_2015;
      15:      tap_mask = 32'h0000_6000;
      16:      tap_mask = 32'h0000_D008;
      17:      tap_mask = 32'h0001_2000;
      18:      tap_mask = 32'h0002_0400;
      19:      tap_mask = 32'h0004_0023;
      20:      tap_mask = 32'h0009_0000;
      21:      tap_mask = 32'h0014_0000;
      22:      tap_mask = 32'h0030_0000;
      23:      tap_mask = 32'h0042_0000;
      24:      tap_mask = 32'h00E1_0000;
      25:      tap_mask = 32'h0120_0000;
      26:      tap_mask = 32'h0200_0023;
      27:      tap_mask = 32'h0400_0013;
      28:      tap_mask = 32'h0900_0000;
      29:      tap_mask = 32'h1400_0000;
      30:      tap_mask = 32'h2000_0029;
      31:      tap_mask = 32'h4800_0000;
      32:      tap_mask = 32'h8020_0003;
      default: tap_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR with reseed. A zero reseed value is replaced by
// SEED so the register can never lock up in the all-zero state.
module lfsr_gen
  import rand_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED = 'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] state
);

  localparam logic [31:0]      MASK_FULL = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] MASK      = MASK_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] next_state;

  // One Galois step: shift right, fold the mask in when a one drops out.
  always_comb begin
    // NOTE: assigning a default before any condition keeps always_comb free
    // of inferred latches on every path.
    next_state = state >> 1;
    if (state[0]) begin
      next_state = (state >> 1) ^ MASK;
    end
  end

  // Register: synchronous reset to SEED, reseed has priority over stepping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from the same edge.
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= (load_value == '0) ? SEED : load_value;
    end else begin
      state <= next_state;
    end
  end

endmodule

// File: rtl/range_rand_gen.sv
// Range-limited random number generator using rejection sampling on an LFSR.
// Requests with a low bound at or below THRESH answer 0 immediately, inverted
// ranges report an error, and a request that misses MAX_TRIES times in a row
// falls back to its low bound.
module range_rand_gen
  import rand_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED      = 'hA5,
  parameter int               MAX_TRIES = 16,
  parameter int               THRESH    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_lo,
  input  logic [WIDTH-1:0] req_hi,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_fallback,
  output logic             rsp_err,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_value
);

  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);
  localparam logic [7:0]       LAST_TRY = 8'(MAX_TRIES - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] hi_q;
  logic [7:0]       tries;
  logic [7:0]       tries_next;
  logic [WIDTH-1:0] data_next;
  logic             zero_next;
  logic             fb_next;
  logic             err_next;
  logic [WIDTH-1:0] lfsr_state;
  logic             hit;
  logic             accept;

  lfsr_gen #(
    .WIDTH (WIDTH),
    .SEED  (SEED)
  ) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (seed_load),
    .load_value (seed_value),
    .state      (lfsr_state)
  );

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  // The candidate is the register output, so a coincident reseed only affects
  // the following cycle's candidate.
  assign hit       = (lfsr_state >= lo_q) && (lfsr_state <= hi_q);

  // Next-state and next-response decode for the request FSM.
  always_comb begin
    state_next = state;
    tries_next = tries;
    data_next  = rsp_data;
    zero_next  = rsp_zero;
    fb_next    = rsp_fallback;
    err_next   = rsp_err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          zero_next = 1'b0;
          fb_next   = 1'b0;
          err_next  = 1'b0;
          // Inverted range is checked before the threshold shortcut.
          if (req_lo > req_hi) begin
            state_next = RESP;
            data_next  = '0;
            err_next   = 1'b1;
          end else if (req_lo <= THRESH_W) begin
            state_next = RESP;
            data_next  = '0;
            zero_next  = 1'b1;
          end else begin
            state_next = DRAW;
            tries_next = 8'd0;
          end
        end
      end
      DRAW: begin
        if (hit) begin
          state_next = RESP;
          data_next  = lfsr_state;
        end else if (tries == LAST_TRY) begin
          state_next = RESP;
          data_next  = lo_q;
          fb_next    = 1'b1;
        end else begin
          tries_next = tries + 8'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          zero_next  = 1'b0;
          fb_next    = 1'b0;
          err_next   = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: captured bounds, try counter and the response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_q         <= '0;
      hi_q         <= '0;
      tries        <= 8'd0;
      rsp_data     <= '0;
      rsp_zero     <= 1'b0;
      rsp_fallback <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      if (accept) begin
        lo_q <= req_lo;
        hi_q <= req_hi;
      end
      tries        <= tries_next;
      rsp_data     <= data_next;
      rsp_zero     <= zero_next;
      rsp_fallback <= fb_next;
      rsp_err      <= err_next;
    end
  end

endmodule

// File: tb/tb_range_rand_gen.sv
// Directed bench for range_rand_gen. Instance 0 uses default parameters,
// instance 1 uses MAX_TRIES=4. Draw-path results come from an independent
// 8-bit Galois LFSR reference (mask 0xB8) tracked cycle by cycle.
module tb_range_rand_gen;

  typedef enum int {K_ZERO, K_ERR, K_DRAW} kind_t;

  logic            clk;
  logic            rst_n;
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0][7:0] req_lo;
  logic [1:0][7:0] req_hi;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [1:0][7:0] rsp_data;
  logic [1:0]      rsp_zero;
  logic [1:0]      rsp_fallback;
  logic [1:0]      rsp_err;
  logic [1:0]      seed_load;
  logic [1:0][7:0] seed_value;
  logic [1:0][7:0] m;

  int total = 0;
  int bad   = 0;
  int lat;

  range_rand_gen u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid[0]),
    .req_ready    (req_ready[0]),
    .req_lo       (req_lo[0]),
    .req_hi       (req_hi[0]),
    .rsp_valid    (rsp_valid[0]),
    .rsp_ready    (rsp_ready[0]),
    .rsp_data     (rsp_data[0]),
    .rsp_zero     (rsp_zero[0]),
    .rsp_fallback (rsp_fallback[0]),
    .rsp_err      (rsp_err[0]),
    .seed_load    (seed_load[0]),
    .seed_value   (seed_value[0])
  );

  range_rand_gen #(.MAX_TRIES(4)) u_dut4 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid[1]),
    .req_ready    (req_ready[1]),
    .req_lo       (req_lo[1]),
    .req_hi       (req_hi[1]),
    .rsp_valid    (rsp_valid[1]),
    .rsp_ready    (rsp_ready[1]),
    .rsp_data     (rsp_data[1]),
    .rsp_zero     (rsp_zero[1]),
    .rsp_fallback (rsp_fallback[1]),
    .rsp_err      (rsp_err[1]),
    .seed_load    (seed_load[1]),
    .seed_value   (seed_value[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] step(input logic [7:0] v);
    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
  endfunction

  // Reference LFSR for each instance.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n)             m[i] <= 8'hA5;
      else if (seed_load[i])  m[i] <= (seed_value[i] == 8'h00) ? 8'hA5 : seed_value[i];
      else                    m[i] <= step(m[i]);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request on instance u, check latency, response and handshake.
  task automatic do_req(input int u, input logic [7:0] lo, input logic [7:0] hi,
                        input kind_t kind, input int stall, input string tag,
                        output int lat_o);
    logic [7:0] ed;
    logic [7:0] v;
    logic       ez, ef, ee;
    int         el, maxt, k;
    req_valid[u] = 1'b1;
    req_lo[u]    = lo;
    req_hi[u]    = hi;
    check({tag, "_ready"}, 32'(req_ready[u]), 32'd1);
    tick;
    req_valid[u] = 1'b0;
    ed = 8'h00; ez = 1'b0; ef = 1'b0; ee = 1'b0; el = 1;
    case (kind)
      K_ZERO: ez = 1'b1;
      K_ERR:  ee = 1'b1;
      default: begin
        maxt = (u == 0) ? 16 : 4;
        v  = m[u];
        ef = 1'b1;
        ed = lo;
        el = maxt + 1;
        for (int t = 0; t < maxt; t++) begin
          if (v >= lo && v <= hi) begin
            ed = v; ef = 1'b0; el = t + 2;
            break;
          end
          v = step(v);
        end
      end
    endcase
    k = 1;
    while (!rsp_valid[u] && k < 40) begin
      tick;
      k++;
    end
    lat_o = k;
    check({tag, "_lat"},  32'(k), 32'(el));
    check({tag, "_data"}, 32'(rsp_data[u]), 32'(ed));
    check({tag, "_zero"}, 32'(rsp_zero[u]), 32'(ez));
    check({tag, "_fb"},   32'(rsp_fallback[u]), 32'(ef));
    check({tag, "_err"},  32'(rsp_err[u]), 32'(ee));
    if (kind == K_DRAW) begin
      check({tag, "_rng"}, 32'(rsp_data[u] >= lo && rsp_data[u] <= hi), 32'd1);
    end
    for (int s = 0; s < stall; s++) begin
      tick;
      check({tag, "_st_valid"}, 32'(rsp_valid[u]), 32'd1);
      check({tag, "_st_ready"}, 32'(req_ready[u]), 32'd0);
      check({tag, "_st_data"},  32'(rsp_data[u]), 32'(ed));
      check({tag, "_st_flags"}, 32'({rsp_zero[u], rsp_fallback[u], rsp_err[u]}),
            32'({ez, ef, ee}));
    end
    rsp_ready[u] = 1'b1;
    tick;
    rsp_ready[u] = 1'b0;
    check({tag, "_hs_valid"}, 32'(rsp_valid[u]), 32'd0);
    check({tag, "_hs_ready"}, 32'(req_ready[u]), 32'd1);
    check({tag, "_hs_flags"}, 32'({rsp_zero[u], rsp_fallback[u], rsp_err[u]}), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = '0;
    req_lo     = '0;
    req_hi     = '0;
    rsp_ready  = '0;
    seed_load  = '0;
    seed_value = '0;

    // Reset state.
    tick;
    tick;
    check("rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("rst_data",  32'(rsp_data[0]), 32'd0);
    check("rst_flags", 32'({rsp_zero[0], rsp_fallback[0], rsp_err[0]}), 32'd0);
    rst_n = 1'b1;
    check("rst_ready", 32'(req_ready[0]), 32'd1);
    check("rst_lfsr",  32'(u_dut.lfsr_state), 32'hA5);

    // Threshold and error paths, including the boundaries.
    do_req(0, 8'd3,   8'd200, K_ZERO, 0, "thr_3_200", lat);
    do_req(0, 8'd10,  8'd20,  K_ZERO, 0, "thr_10_20", lat);
    do_req(0, 8'd0,   8'd0,   K_ZERO, 0, "thr_0_0", lat);
    do_req(0, 8'd50,  8'd20,  K_ERR,  0, "err_50_20", lat);
    do_req(0, 8'd5,   8'd4,   K_ERR,  0, "err_5_4", lat);
    do_req(0, 8'd255, 8'd11,  K_ERR,  0, "err_255_11", lat);

    // Draw path, first value above the threshold.
    for (int i = 0; i < 100; i++) begin
      do_req(0, 8'd11, 8'd255, K_DRAW, 0, "draw_11_255", lat);
    end
    do_req(0, 8'd11, 8'd11, K_DRAW, 0, "draw_11_11", lat);

    // Single-value range with MAX_TRIES=4: mostly fallback, bounded latency.
    for (int i = 0; i < 20; i++) begin
      do_req(1, 8'h80, 8'h80, K_DRAW, 0, "t4_80", lat);
      check("t4_80_maxlat", 32'(lat <= 5), 32'd1);
    end

    // Response stall: outputs hold while rsp_ready is low.
    do_req(0, 8'd11, 8'd255, K_DRAW, 5, "stall", lat);

    // Reset in the middle of a DRAW abandons the request.
    req_valid[0] = 1'b1;
    req_lo[0]    = 8'd40;
    req_hi[0]    = 8'd255;
    tick;
    req_valid[0] = 1'b0;
    check("mid_draw_valid", 32'(rsp_valid[0]), 32'd0);
    check("mid_draw_ready", 32'(req_ready[0]), 32'd0);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("post_rst_ready", 32'(req_ready[0]), 32'd1);
    check("post_rst_valid", 32'(rsp_valid[0]), 32'd0);
    check("post_rst_data",  32'(rsp_data[0]), 32'd0);
    check("post_rst_lfsr",  32'(u_dut.lfsr_state), 32'hA5);
    for (int i = 0; i < 4; i++) begin
      tick;
      check("post_rst_idle", 32'({rsp_valid[0], req_ready[0]}), 32'b01);
    end

    // Reseed: zero maps to SEED, nonzero loads directly.
    seed_load[0]  = 1'b1;
    seed_value[0] = 8'h00;
    tick;
    seed_load[0]  = 1'b0;
    check("seed_zero", 32'(u_dut.lfsr_state), 32'hA5);
    seed_load[0]  = 1'b1;
    seed_value[0] = 8'h3C;
    tick;
    seed_load[0]  = 1'b0;
    check("seed_3c", 32'(u_dut.lfsr_state), 32'h3C);
    tick;
    check("seed_step", 32'(u_dut.lfsr_state), 32'h1E);

    // Reseed during DRAW: the pre-load value (0x40 -> 0x20) is the candidate.
    seed_load[0]  = 1'b1;
    seed_value[0] = 8'h40;
    tick;
    seed_load[0]  = 1'b0;
    check("seed_40", 32'(u_dut.lfsr_state), 32'h40);
    req_valid[0] = 1'b1;
    req_lo[0]    = 8'h20;
    req_hi[0]    = 8'h20;
    tick;
    req_valid[0]  = 1'b0;
    seed_load[0]  = 1'b1;
    seed_value[0] = 8'h77;
    check("draw_seed_pre", 32'(rsp_valid[0]), 32'd0);
    tick;
    seed_load[0] = 1'b0;
    check("draw_seed_valid", 32'(rsp_valid[0]), 32'd1);
    check("draw_seed_data",  32'(rsp_data[0]), 32'h20);
    check("draw_seed_fb",    32'(rsp_fallback[0]), 32'd0);
    check("draw_seed_lfsr",  32'(u_dut.lfsr_state), 32'h77);
    rsp_ready[0] = 1'b1;
    tick;
    rsp_ready[0] = 1'b0;
    check("draw_seed_hs", 32'(rsp_valid[0]), 32'd0);
    check("lfsr_track0", 32'(u_dut.lfsr_state), 32'(m[0]));
    check("lfsr_track1", 32'(u_dut4.lfsr_state), 32'(m[1]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
